mix_pipe: RTL and testbench
===========================

MIX_PIPE -- requirements
Module: mix_pipe

Interface
REQ-001 SHALL have parameter W, default 12, lane width in bits; legal range W >= 4.
REQ-002 SHALL have parameter NCH, default 4, number of lanes; legal range NCH >= 1.
REQ-003 SHALL have parameter HI, default 7, upper bit of the extract field; legal range LO <= HI < W.
REQ-004 SHALL have parameter LO, default 3, lower bit of the extract field; legal range 0 <= LO <= HI.
REQ-005 SHALL have port clk, input, 1 bit, sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit, reset; synchronous and active-high.
REQ-007 SHALL have port in_valid, input, 1 bit; the input beat is offered.
REQ-008 SHALL have port in_ready, output, 1 bit; the block can accept the offered beat.
REQ-009 SHALL have port in_data, input, NCH*W bits; lane i occupies bits [i*W+W-1 : i*W].
REQ-010 SHALL have port mode, input, 2 bits; the lane operation, sampled with in_data.
REQ-011 SHALL have port out_valid, output, 1 bit; a result beat is presented.
REQ-012 SHALL have port out_ready, input, 1 bit; the consumer accepts the result beat.
REQ-013 SHALL have port out_data, output, NCH*W bits; result lanes, same packing as in_data.
REQ-014 SHALL have port sig, output, W bits; running XOR signature of transferred results.
REQ-015 SHALL have port cnt, output, 16 bits; count of output transfers.

Function
REQ-016 SHALL transfer an input beat on a cycle where in_valid and in_ready are both 1, and an output beat on a cycle where out_valid and out_ready are both 1.
REQ-017 SHALL be a 2-stage pipeline: S1 registers in_data and mode; S2 registers the computed lane results.
- out_valid is S2's valid flag.
REQ-018 SHALL define the stage advance conditions as follows:
- S2 loads when S1 is valid and (S2 is empty or out_ready = 1).
- S1 loads when in_valid and in_ready are both 1.
- in_ready = !rst && (S1 empty || S2 loads this cycle).
REQ-019 SHALL give latency of exactly 2 cycles from input transfer to out_valid = 1 when unstalled, and sustain 1 beat per cycle throughput.
REQ-020 SHALL keep out_data stable while out_valid = 1 and out_ready = 0, and never drop, duplicate or reorder beats.
REQ-021 SHALL compute each result lane i from x = lane i and n = lane (i+1) mod NCH of the same beat (for NCH = 1, n = x), according to the sampled mode:
- mode 0 (EXTRACT): x[HI:LO], zero-extended to W bits.
- mode 1 (XNOR): x ~^ n.
- mode 2 (NOR): bit 0 = ~|x[HI:LO]; all other bits 0.
- mode 3 (SHIFT): logical x >> n[S-1:0], with S = clog2(W); a shift amount >= W yields 0.
REQ-022 SHALL apply mode per beat, so consecutive beats may use different modes with no bubble.
REQ-023 SHALL update sig on each output transfer to sig XOR (XOR of all NCH lanes of out_data).
REQ-024 SHALL increment cnt by 1 on each output transfer, wrapping from 0xFFFF to 0x0000.
REQ-025 SHALL, when an output transfer and an input transfer occur in the same cycle, perform both; a full pipeline with out_ready = 1 keeps in_ready = 1.

Reset
REQ-026 SHALL, while rst = 1, clear S1 and S2 valid, set out_data = 0, sig = 0 and cnt = 0, and hold in_ready = 0.
REQ-027 SHALL discard in-flight beats when rst is asserted mid-operation, with no output transfer, sig change or cnt change on a rst cycle.
REQ-028 SHALL set in_ready = 1 in the first cycle after rst deasserts, and set out_valid = 0 until a new beat completes 2 stages.

Verification (W=12, NCH=4, HI=7, LO=3)
REQ-029 SHALL cover reset: rst high for 2 cycles mid-stream -> out_valid = 0, sig = 0x000, cnt = 0, in_ready = 0 during rst and 1 the cycle after.
REQ-030 SHALL cover EXTRACT: mode 0, lane0 = 0x0F8 -> out lane0 = 0x01F, out_valid high exactly 2 cycles after the accept.
REQ-031 SHALL cover NOR: mode 2, lane0 = 0x807 -> 0x001; next beat lane0 = 0x808 -> 0x000, back-to-back with no bubble.
REQ-032 SHALL cover SHIFT: mode 3, lane0 = 0x800 and lane1 = 0x003 -> lane0 result 0x100; lane1 = 0x00C -> lane0 result 0x000.
REQ-033 SHALL cover backpressure: out_ready = 0 with 3 beats offered -> exactly 2 accepted and in_ready = 0; then out_ready = 1 -> 3 beats out in order, cnt = 3.
REQ-034 SHALL cover sig: two transfers whose lane-XORs are 0x0A5 and 0x0F0 -> sig = 0x055; the same check with out_ready toggled every cycle gives an identical sig.

Source files
------------

// File: rtl/mix_pipe.sv
// mix_pipe: 2-stage lane-op pipeline (extract / xnor / nor / shift) with running XOR signature and transfer count.
// Latency 2 cycles at 1 beat/cycle; a stalled output holds its beat and backs up through in_ready.
module mix_pipe #(
  parameter int W   = 12,
  parameter int NCH = 4,
  parameter int HI  = 7,
  parameter int LO  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NCH*W-1:0] in_data,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NCH*W-1:0] out_data,
  output logic [W-1:0]     sig,
  output logic [15:0]      cnt
);

  localparam int S  = $clog2(W);
  localparam int DW = NCH * W;

  typedef struct packed {
    logic [1:0]    op;
    logic [DW-1:0] dat;
  } beat_t;

  beat_t         s1_q;
  logic          s1_vld;
  logic          s2_vld;
  logic [DW-1:0] s2_dat;
  logic [W-1:0]  sig_q;
  logic [15:0]   cnt_q;

  logic          s2_load;
  logic          in_xfer;
  logic          out_xfer;
  logic [DW-1:0] res;
  logic [W-1:0]  lane_x;
  logic [W-1:0]  lane_n;
  logic [W-1:0]  lane_r;
  logic [W-1:0]  out_xor;

  assign s2_load   = s1_vld && (!s2_vld || out_ready);
  assign in_ready  = !rst && (!s1_vld || s2_load);
  assign in_xfer   = in_valid && in_ready;

  // Outputs are forced quiet during reset so no transfer can be seen on a reset cycle.
  assign out_valid = s2_vld && !rst;
  assign out_xfer  = out_valid && out_ready;
  assign out_data  = rst ? '0 : s2_dat;
  assign sig       = rst ? '0 : sig_q;
  assign cnt       = rst ? '0 : cnt_q;

  // Lane i pairs with its cyclic neighbour (i+1) mod NCH; with NCH = 1 that is itself.
  always_comb begin
    res    = '0;
    lane_x = '0;
    lane_n = '0;
    lane_r = '0;
    for (int i = 0; i < NCH; i++) begin
      lane_x = s1_q.dat[i*W +: W];
      lane_n = s1_q.dat[((i + 1) % NCH)*W +: W];
      lane_r = '0;
      unique case (s1_q.op)
        2'd0: lane_r[HI-LO:0] = lane_x[HI:LO];
        2'd1: lane_r = lane_x ~^ lane_n;
        2'd2: lane_r[0] = ~|lane_x[HI:LO];
        default: lane_r = (32'(lane_n[S-1:0]) >= W) ? '0 : (lane_x >> lane_n[S-1:0]);
      endcase
      res[i*W +: W] = lane_r;
    end
  end

  always_comb begin
    out_xor = '0;
    for (int i = 0; i < NCH; i++) begin
      out_xor = out_xor ^ s2_dat[i*W +: W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_q   <= '0;
      s2_vld <= 1'b0;
      s2_dat <= '0;
      sig_q  <= '0;
      cnt_q  <= '0;
    end else begin
      if (in_xfer) begin
        s1_q.op  <= mode;
        s1_q.dat <= in_data;
        s1_vld   <= 1'b1;
      end else if (s2_load) begin
        s1_vld <= 1'b0;
      end

      if (s2_load) begin
        s2_vld <= 1'b1;
        s2_dat <= res;
      end else if (out_xfer) begin
        s2_vld <= 1'b0;
      end

      if (out_xfer) begin
        sig_q <= sig_q ^ out_xor;
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mix_pipe.sv
// Bench for mix_pipe at W=12, NCH=4, HI=7, LO=3: queue-based reference model checked every cycle,
// plus directed beats with hand-computed results.
module tb_mix_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [47:0] in_data = '0;
  logic [1:0]  mode = 2'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [47:0] out_data;
  logic [11:0] sig;
  logic [15:0] cnt;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [47:0] d;
    int          acc;
  } ent_t;

  ent_t        q[$];
  logic [47:0] cap[$];
  int          capc[$];
  logic [11:0] m_sig = '0;
  logic [15:0] m_cnt = '0;
  int          cyc = 0;

  always #5 clk = ~clk;

  mix_pipe #(.W(12), .NCH(4), .HI(7), .LO(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .sig(sig), .cnt(cnt)
  );

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference lane operations written straight from the arithmetic definitions.
  function automatic logic [47:0] model(input logic [47:0] d, input logic [1:0] m);
    logic [47:0] r;
    int x, n, v, s;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      x = int'(d[i*12 +: 12]);
      n = int'(d[((i + 1) % 4)*12 +: 12]);
      case (m)
        2'd0: v = (x >> 3) % 32;
        2'd1: v = (x ^ n) ^ 4095;
        2'd2: v = (((x >> 3) % 32) == 0) ? 1 : 0;
        default: begin
          s = n % 16;
          v = (s >= 12) ? 0 : (x >> s);
        end
      endcase
      r[i*12 +: 12] = 12'(v);
    end
    return r;
  endfunction

  function automatic logic [11:0] lxor(input logic [47:0] d);
    return d[11:0] ^ d[23:12] ^ d[35:24] ^ d[47:36];
  endfunction

  // Pipeline modelled as a queue of in-flight beats tagged with their accept cycle.
  always @(negedge clk) begin : cmp
    logic er, ev;
    ent_t e;
    er = !rst && (q.size() < 2 || out_ready);
    ev = !rst && (q.size() > 0) && (cyc >= q[0].acc + 2);
    check("in_ready", 48'(in_ready), 48'(er));
    check("out_valid", 48'(out_valid), 48'(ev));
    check("sig", 48'(sig), rst ? 48'h0 : 48'(m_sig));
    check("cnt", 48'(cnt), rst ? 48'h0 : 48'(m_cnt));
    if (rst) check("out_data_rst", out_data, 48'h0);
    else if (ev) check("out_data", out_data, q[0].d);
    if (rst) begin
      q.delete();
      m_sig = '0;
      m_cnt = '0;
    end else begin
      if (ev && out_ready) begin
        m_sig = m_sig ^ lxor(q[0].d);
        m_cnt = m_cnt + 16'd1;
        cap.push_back(out_data);
        capc.push_back(cyc);
        void'(q.pop_front());
      end
      if (in_valid && er) begin
        e.d   = model(in_data, mode);
        e.acc = cyc;
        q.push_back(e);
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [47:0] d, input logic [1:0] m);
    bit acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    mode     = m;
    for (int k = 0; k < 40 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
    end
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL push_timeout: in_ready stayed 0, wanted 1");
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_caps(input int n);
    for (int k = 0; k < 60 && cap.size() < n; k++) tick();
    if (cap.size() < n) begin
      n_cmp++;
      n_bad++;
      $display("FAIL out_timeout: got %0d beats want %0d", cap.size(), n);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : drive
    logic [47:0] b[3];
    int  na;
    bit  acc;
    bit  gdone;

    // Power-on reset
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    check("A_ready_after_rst", 48'(in_ready), 48'h1);
    tick();

    // EXTRACT and its 2-cycle latency
    cap.delete();
    push({12'hFFF, 12'h456, 12'h123, 12'h0F8}, 2'd0);
    @(negedge clk);
    check("B_valid_cycle1", 48'(out_valid), 48'h0);
    tick();
    @(negedge clk);
    check("B_valid_cycle2", 48'(out_valid), 48'h1);
    check("B_extract_lane0", 48'(out_data[11:0]), 48'h01F);
    tick();

    // NOR back-to-back
    cap.delete();
    capc.delete();
    push(48'h807, 2'd2);
    push(48'h808, 2'd2);
    wait_caps(2);
    check("C_nor_0x807", 48'(cap[0][11:0]), 48'h001);
    check("C_nor_0x808", 48'(cap[1][11:0]), 48'h000);
    check("C_no_bubble", 48'(capc[1] - capc[0]), 48'h1);

    // SHIFT, including an out-of-range amount
    cap.delete();
    push({24'h0, 12'h003, 12'h800}, 2'd3);
    push({24'h0, 12'h00C, 12'h800}, 2'd3);
    wait_caps(2);
    check("D_shift_by3", 48'(cap[0][11:0]), 48'h100);
    check("D_shift_by12", 48'(cap[1][11:0]), 48'h000);

    // Reset with beats in flight
    out_ready = 1'b0;
    push(48'h111, 2'd0);
    push(48'h222, 2'd0);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("R_valid_in_rst", 48'(out_valid), 48'h0);
      check("R_sig_in_rst", 48'(sig), 48'h0);
      check("R_cnt_in_rst", 48'(cnt), 48'h0);
      check("R_ready_in_rst", 48'(in_ready), 48'h0);
      tick();
    end
    rst = 1'b0;
    @(negedge clk);
    check("R_ready_after", 48'(in_ready), 48'h1);
    tick();
    repeat (3) begin
      @(negedge clk);
      check("R_discarded", 48'(out_valid), 48'h0);
      tick();
    end

    // Backpressure: only two slots
    cap.delete();
    b[0] = 48'h008;
    b[1] = 48'h010;
    b[2] = 48'h018;
    na = 0;
    in_valid = 1'b1;
    mode = 2'd0;
    repeat (6) begin
      in_data = b[(na > 2) ? 2 : na];
      @(negedge clk);
      acc = in_ready;
      tick();
      if (acc) na++;
    end
    check("E_accepted", 48'(na), 48'h2);
    @(negedge clk);
    check("E_ready_stalled", 48'(in_ready), 48'h0);
    tick();
    out_ready = 1'b1;
    in_data = b[2];
    acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
    end
    check("E_third_accept", 48'(acc), 48'h1);
    in_valid = 1'b0;
    wait_caps(3);
    @(negedge clk);
    check("E_cnt", 48'(cnt), 48'h3);
    check("E_order0", 48'(cap[0][11:0]), 48'h001);
    check("E_order1", 48'(cap[1][11:0]), 48'h002);
    check("E_order2", 48'(cap[2][11:0]), 48'h003);
    tick();

    // Signature, steady then with out_ready toggling
    do_reset(1);
    out_ready = 1'b1;
    cap.delete();
    push({12'h0A5, 36'h0}, 2'd3);
    push({12'h0F0, 36'h0}, 2'd3);
    wait_caps(2);
    @(negedge clk);
    check("F_sig", 48'(sig), 48'h055);
    tick();
    do_reset(1);
    out_ready = 1'b0;
    cap.delete();
    fork
      begin
        push({12'h0A5, 36'h0}, 2'd3);
        push({12'h0F0, 36'h0}, 2'd3);
      end
      begin
        repeat (12) begin
          tick();
          out_ready = ~out_ready;
        end
      end
    join
    out_ready = 1'b1;
    wait_caps(2);
    @(negedge clk);
    check("F_sig_toggle", 48'(sig), 48'h055);
    check("F_cnt_toggle", 48'(cnt), 48'h2);
    tick();

    // Mixed-mode stream under random backpressure
    gdone = 1'b0;
    fork
      begin
        for (int k = 0; k < 60; k++) begin
          push(48'({$urandom(), $urandom()}), 2'($urandom_range(0, 3)));
          if ($urandom_range(0, 3) == 0) tick();
        end
        gdone = 1'b1;
      end
      begin
        while (!gdone) begin
          tick();
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    repeat (10) tick();
    @(negedge clk);
    check("G_cnt", 48'(cnt), 48'd62);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
